pit_bus_frontend: RTL and testbench
===================================

// Module: pit_bus_frontend
// PURPOSE
//  Host-side front end of the 8253-compatible PIT, sitting directly upstream of the three counter slices.
//  Turns CPU strobes (CS#/RD#/WR#, A[1:0], D[7:0]) into one-clock write pulses per counter and a shared internal data bus.
//  Also produces per-counter read levels and muxes the counters' read data back to the CPU.
//  Generates the shared ~1.193182 MHz counter_clock square wave with a phase accumulator.
// PARAMETERS
//  ACC_WIDTH   24      phase accumulator width (bits)
//  PHASE_INC   400365  accumulator increment per clock; f_out = f_clock*PHASE_INC/2^ACC_WIDTH (1.193182 MHz @ 50 MHz)
// PORTS
//  clock                  in   1  system clock; all inputs synchronous to it
//  reset                  in   1  synchronous, active-high
//  chip_select_n          in   1  PIT chip select, active low
//  read_enable_n          in   1  CPU read strobe, active low
//  write_enable_n         in   1  CPU write strobe, active low
//  address                in   2  register select: 0..2 counter n, 3 control word
//  data_bus_in            in   8  CPU write data
//  data_bus_out           out  8  CPU read data
//  data_bus_out_en        out  1  high while a counter read is being driven
//  internal_data_bus      out  8  latched write data to all counter slices
//  write_control_0/1/2    out  1  one-clock pulse: control word for counter n
//  write_counter_0/1/2    out  1  one-clock pulse: count byte for counter n
//  read_counter_0/1/2     out  1  level: counter n is being read
//  read_counter_data_0/1/2 in  8  read data from counter n
//  counter_clock          out  1  timer input clock, shared by all counters
// BEHAVIOUR
//  Reset: every output 0; accumulator 0; internal write/read strobe registers 0.
//  wr_act = ~chip_select_n & ~write_enable_n; rd_act = ~chip_select_n & ~read_enable_n & ~wr_act. Write wins on overlap.
//  Write capture: in each cycle with wr_act=1, register address and data_bus_in into addr_q and data_q. The last value before release wins.
//  Write commit: on the cycle after wr_act falls (registered wr_act=1, current=0), drive exactly one pulse for 1 clock:
//   - addr_q 0/1/2: write_counter_<addr_q>.
//   - addr_q 3: decode data_q[7:6]. 00/01/10 pulse write_control_0/1/2; 11 is illegal, so no pulse.
//  internal_data_bus <= data_q on the commit cycle and is held until the next commit. It is valid in the same cycle as the pulse.
//  A held WR# produces exactly one commit. A strobe longer than one clock commits once, on release.
//  Read: read_counter_n <= rd_act & (address==n), registered, so latency is 1 clock.
//   - It stays high for the strobe duration and falls 1 clock after release; the counter slice detects that negedge.
//   - address 3 read: no read_counter asserted; data_bus_out = 8'h00.
//  data_bus_out <= read_counter_data_<address> while rd_act, registered. data_bus_out_en <= rd_act (same timing).
//   - When not reading, data_bus_out holds 8'h00.
//  Chip select removal counts as strobe release: commit or read-end as above.
//  Reset asserted mid-strobe: the capture is discarded and no pulse is generated, including at the release after reset.
//   - After reset, a strobe already asserted is committed only if it is seen going active again.
//  Clock generator: acc <= acc + PHASE_INC every clock (mod 2^ACC_WIDTH); counter_clock = acc[ACC_WIDTH-1], registered.
//   - Jitter is at most 1 system clock per edge. counter_clock never stops except during reset.
// TESTING
//  1. WR# low 3 clocks, A=3, D=0x36, then release -> write_control_0=1 for exactly 1 clock, internal_data_bus=0x36. No other pulses.
//  2. Control writes D=0x76, 0xB6, 0xF6 -> write_control_1, then write_control_2, then no pulse at all.
//  3. A=1: write D=0x34 then D=0x12 -> two write_counter_1 pulses; internal_data_bus=0x34, then 0x12.
//  4. Read with A=2, read_counter_data_2=0xA5 held 4 clocks -> read_counter_2 high from +1 clock until 1 clock after release.
//     data_bus_out=0xA5 and data_bus_out_en=1 over the same window. Other read_counter signals stay 0.
//  5. WR# and RD# both low, A=0 -> only write_counter_0 pulses; read_counter_0 stays 0.
//  6. Run 2^24 clocks from reset -> 400365 +/-1 rising edges of counter_clock.
//     A reset during an active write strobe -> no write pulse.

Source files
------------

// File: rtl/pit_bus_frontend_if.sv
// rtl/pit_bus_frontend_if.sv - CPU-side strobe/data bus of the PIT front end
interface pit_bus_frontend_if;
   logic       chip_select_n;
   logic       read_enable_n;
   logic       write_enable_n;
   logic [1:0] address;
   logic [7:0] data_bus_in;
   logic [7:0] data_bus_out;
   logic       data_bus_out_en;

   modport master (
      output chip_select_n, read_enable_n, write_enable_n, address, data_bus_in,
      input  data_bus_out, data_bus_out_en
   );

   modport slave (
      input  chip_select_n, read_enable_n, write_enable_n, address, data_bus_in,
      output data_bus_out, data_bus_out_en
   );
endinterface

// File: rtl/pit_bus_frontend.sv
// rtl/pit_bus_frontend.sv - PIT host front end: strobe decode, read mux, counter clock
module pit_bus_frontend #(
   parameter int ACC_WIDTH = 24,
   parameter int PHASE_INC = 400365
) (
   input  logic                clock,
   input  logic                reset,
   pit_bus_frontend_if.slave   cpu,
   output logic [7:0]          internal_data_bus,
   output logic                write_control_0,
   output logic                write_control_1,
   output logic                write_control_2,
   output logic                write_counter_0,
   output logic                write_counter_1,
   output logic                write_counter_2,
   output logic                read_counter_0,
   output logic                read_counter_1,
   output logic                read_counter_2,
   input  logic [7:0]          read_counter_data_0,
   input  logic [7:0]          read_counter_data_1,
   input  logic [7:0]          read_counter_data_2,
   output logic                counter_clock
);
   logic                 wr_act;
   logic                 rd_act;
   logic                 armed;
   logic                 wr_q;
   logic [1:0]           addr_q;
   logic [7:0]           data_q;
   logic [7:0]           rd_mux;
   logic [ACC_WIDTH-1:0] acc;

   assign wr_act = ~cpu.chip_select_n & ~cpu.write_enable_n;
   assign rd_act = ~cpu.chip_select_n & ~cpu.read_enable_n & ~wr_act;

   always_comb begin
      rd_mux = 8'h00;
      case (cpu.address)
         2'd0:    rd_mux = read_counter_data_0;
         2'd1:    rd_mux = read_counter_data_1;
         2'd2:    rd_mux = read_counter_data_2;
         default: rd_mux = 8'h00;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         armed               <= 1'b0;
         wr_q                <= 1'b0;
         addr_q              <= 2'd0;
         data_q              <= 8'h00;
         internal_data_bus   <= 8'h00;
         write_control_0     <= 1'b0;
         write_control_1     <= 1'b0;
         write_control_2     <= 1'b0;
         write_counter_0     <= 1'b0;
         write_counter_1     <= 1'b0;
         write_counter_2     <= 1'b0;
         read_counter_0      <= 1'b0;
         read_counter_1      <= 1'b0;
         read_counter_2      <= 1'b0;
         cpu.data_bus_out    <= 8'h00;
         cpu.data_bus_out_en <= 1'b0;
         acc                 <= '0;
         counter_clock       <= 1'b0;
      end else begin
         // A write strobe held across reset is ignored until the bus has been seen idle once.
         armed <= armed | ~wr_act;
         wr_q  <= wr_act & armed;
         if (wr_act & armed) begin
            addr_q <= cpu.address;
            data_q <= cpu.data_bus_in;
         end

         write_control_0 <= 1'b0;
         write_control_1 <= 1'b0;
         write_control_2 <= 1'b0;
         write_counter_0 <= 1'b0;
         write_counter_1 <= 1'b0;
         write_counter_2 <= 1'b0;
         if (wr_q & ~wr_act) begin
            internal_data_bus <= data_q;
            case (addr_q)
               2'd0: write_counter_0 <= 1'b1;
               2'd1: write_counter_1 <= 1'b1;
               2'd2: write_counter_2 <= 1'b1;
               default: begin
                  // Select code 11 is not a counter: the control word is dropped.
                  case (data_q[7:6])
                     2'd0:    write_control_0 <= 1'b1;
                     2'd1:    write_control_1 <= 1'b1;
                     2'd2:    write_control_2 <= 1'b1;
                     default: ;
                  endcase
               end
            endcase
         end

         read_counter_0      <= rd_act & (cpu.address == 2'd0);
         read_counter_1      <= rd_act & (cpu.address == 2'd1);
         read_counter_2      <= rd_act & (cpu.address == 2'd2);
         cpu.data_bus_out    <= rd_act ? rd_mux : 8'h00;
         cpu.data_bus_out_en <= rd_act;

         acc           <= acc + ACC_WIDTH'(PHASE_INC);
         counter_clock <= acc[ACC_WIDTH-1];
      end
   end
endmodule

// File: tb/tb_pit_bus_frontend.sv
// tb/tb_pit_bus_frontend.sv - scoreboard bench for the PIT host front end
module tb_pit_bus_frontend;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] internal_data_bus;
   logic       write_control_0, write_control_1, write_control_2;
   logic       write_counter_0, write_counter_1, write_counter_2;
   logic       read_counter_0, read_counter_1, read_counter_2;
   logic [7:0] read_counter_data_0 = 8'h11;
   logic [7:0] read_counter_data_1 = 8'h5C;
   logic [7:0] read_counter_data_2 = 8'hA5;
   logic       counter_clock;

   int total = 0;
   int bad   = 0;
   bit mon_on = 1'b0;

   // {write_counter_2..0, write_control_2..0, internal_data_bus}
   logic [13:0] wq[$];
   // {read_counter_2..0, data_bus_out, data_bus_out_en}
   logic [11:0] rq[$];

   always #5 clock = ~clock;

   pit_bus_frontend_if bus ();

   pit_bus_frontend dut (
      .clock               (clock),
      .reset               (reset),
      .cpu                 (bus),
      .internal_data_bus   (internal_data_bus),
      .write_control_0     (write_control_0),
      .write_control_1     (write_control_1),
      .write_control_2     (write_control_2),
      .write_counter_0     (write_counter_0),
      .write_counter_1     (write_counter_1),
      .write_counter_2     (write_counter_2),
      .read_counter_0      (read_counter_0),
      .read_counter_1      (read_counter_1),
      .read_counter_2      (read_counter_2),
      .read_counter_data_0 (read_counter_data_0),
      .read_counter_data_1 (read_counter_data_1),
      .read_counter_data_2 (read_counter_data_2),
      .counter_clock       (counter_clock)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      logic [5:0]  wp;
      logic [2:0]  rc;
      logic [13:0] we;
      logic [11:0] re;
      if (mon_on && !reset) begin
         wp = {write_counter_2, write_counter_1, write_counter_0,
               write_control_2, write_control_1, write_control_0};
         rc = {read_counter_2, read_counter_1, read_counter_0};
         if (wp != 6'd0) begin
            if (wq.size() == 0) check("unexpected_write_pulse", {18'd0, wp, internal_data_bus}, 32'd0);
            else begin
               we = wq.pop_front();
               check("write_pulse", {18'd0, wp, internal_data_bus}, {18'd0, we});
            end
         end
         if (rc != 3'd0 || bus.data_bus_out_en) begin
            if (rq.size() == 0) check("unexpected_read", {20'd0, rc, bus.data_bus_out, bus.data_bus_out_en}, 32'd0);
            else begin
               re = rq.pop_front();
               check("read_cycle", {20'd0, rc, bus.data_bus_out, bus.data_bus_out_en}, {20'd0, re});
            end
         end else if (bus.data_bus_out != 8'h00) begin
            check("idle_data_bus_out", {24'd0, bus.data_bus_out}, 32'd0);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic cpu_write(input logic [1:0] a, input logic [7:0] d, input int n,
                            input logic [5:0] exp_pulse, input bit release_cs);
      if (exp_pulse != 6'd0) wq.push_back({exp_pulse, d});
      bus.address        = a;
      bus.data_bus_in    = d;
      bus.chip_select_n  = 1'b0;
      bus.write_enable_n = 1'b0;
      idle(n);
      if (release_cs) bus.chip_select_n = 1'b1;
      else            bus.write_enable_n = 1'b1;
      idle(1);
      bus.chip_select_n  = 1'b1;
      bus.write_enable_n = 1'b1;
      idle(3);
   endtask

   task automatic cpu_read(input logic [1:0] a, input int n, input logic [7:0] d);
      logic [2:0] rc;
      rc = (a == 2'd3) ? 3'd0 : 3'(1 << a);
      for (int i = 0; i < n; i++) rq.push_back({rc, d, 1'b1});
      bus.address       = a;
      bus.chip_select_n = 1'b0;
      bus.read_enable_n = 1'b0;
      idle(n);
      bus.chip_select_n = 1'b1;
      bus.read_enable_n = 1'b1;
      idle(3);
   endtask

   initial begin
      int edges;
      logic prev;
      bus.chip_select_n  = 1'b1;
      bus.read_enable_n  = 1'b1;
      bus.write_enable_n = 1'b1;
      bus.address        = 2'd0;
      bus.data_bus_in    = 8'h00;
      idle(3);
      @(negedge clock);
      check("rst_write_pulses", {26'd0, write_counter_2, write_counter_1, write_counter_0,
                                 write_control_2, write_control_1, write_control_0}, 32'd0);
      check("rst_read_levels", {29'd0, read_counter_2, read_counter_1, read_counter_0}, 32'd0);
      check("rst_data_bus_out", {23'd0, bus.data_bus_out_en, bus.data_bus_out}, 32'd0);
      check("rst_internal_bus", {24'd0, internal_data_bus}, 32'd0);
      check("rst_counter_clock", {31'd0, counter_clock}, 32'd0);
      idle(1);
      reset  = 1'b0;
      mon_on = 1'b1;
      idle(2);

      cpu_write(2'd3, 8'h36, 3, 6'b000001, 1'b0);
      cpu_write(2'd3, 8'h76, 2, 6'b000010, 1'b0);
      cpu_write(2'd3, 8'hB6, 1, 6'b000100, 1'b0);
      cpu_write(2'd3, 8'hF6, 2, 6'b000000, 1'b0);
      cpu_write(2'd1, 8'h34, 2, 6'b010000, 1'b0);
      cpu_write(2'd1, 8'h12, 1, 6'b010000, 1'b0);
      check("internal_bus_hold", {24'd0, internal_data_bus}, 32'h12);
      cpu_write(2'd2, 8'hC3, 2, 6'b100000, 1'b1);

      cpu_read(2'd2, 4, 8'hA5);
      cpu_read(2'd0, 1, 8'h11);
      cpu_read(2'd1, 2, 8'h5C);
      cpu_read(2'd3, 2, 8'h00);

      // Write and read strobes together: the write wins.
      wq.push_back({6'b001000, 8'h5A});
      bus.address        = 2'd0;
      bus.data_bus_in    = 8'h5A;
      bus.chip_select_n  = 1'b0;
      bus.write_enable_n = 1'b0;
      bus.read_enable_n  = 1'b0;
      idle(2);
      bus.write_enable_n = 1'b1;
      bus.read_enable_n  = 1'b1;
      bus.chip_select_n  = 1'b1;
      idle(3);

      // Reset in the middle of a write strobe that stays held past reset.
      bus.address        = 2'd0;
      bus.data_bus_in    = 8'h99;
      bus.chip_select_n  = 1'b0;
      bus.write_enable_n = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      idle(2);
      bus.write_enable_n = 1'b1;
      bus.chip_select_n  = 1'b1;
      idle(4);
      check("no_commit_after_reset", {24'd0, internal_data_bus}, 32'h00);
      cpu_write(2'd2, 8'h77, 1, 6'b100000, 1'b0);

      check("write_queue_drained", wq.size(), 32'd0);
      check("read_queue_drained", rq.size(), 32'd0);

      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      edges = 0;
      prev  = 1'b0;
      repeat (40000) begin
         @(negedge clock);
         if (counter_clock && !prev) edges++;
         prev = counter_clock;
      end
      check("counter_clock_edges_954pm1", {31'd0, (edges >= 953 && edges <= 955)}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
